// File: rtl/nn_pkg.sv
// Shared definitions for the time-multiplexed neuron layer: FSM encoding,
// width helpers and the output saturate/ReLU stage.
package nn_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MAC  = 2'd1,
        S_OUT  = 2'd2
    } state_t;

    // Ceiling log2, never below 1 so it can size a port or counter directly.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return (r < 1) ? 1 : r;
    endfunction

    function automatic int min_acc_w(input int data_w, input int n_in);
        return 2 * data_w + clog2(n_in + 1);
    endfunction

    function automatic logic signed [63:0] sat_relu(input logic signed [63:0] v,
                                                    input int data_w,
                                                    input bit relu);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        logic signed [63:0] r;
        hi = (64'sd1 <<< (data_w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (data_w - 1));
        if (v > hi)
            r = hi;
        else if (v < lo)
            r = lo;
        else
            r = v;
        if (relu && (r < 64'sd0))
            r = 64'sd0;
        return r;
    endfunction

endpackage

// File: rtl/nn_mac_unit.sv
// Single multiplier/accumulator: loads bias or accumulates one product per
// enabled cycle and exposes the rescaled, saturated value of the next acc.
module nn_mac_unit
    import nn_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int FRAC_W   = 8,
    parameter int ACC_W    = 40,
    parameter int RELU_OUT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              load,
    input  logic [DATA_W-1:0] x,
    input  logic [DATA_W-1:0] w,
    input  logic [DATA_W-1:0] bias,
    output logic [DATA_W-1:0] res
);

    logic signed [DATA_W-1:0]   x_s;
    logic signed [DATA_W-1:0]   w_s;
    logic signed [DATA_W-1:0]   b_s;
    logic signed [2*DATA_W-1:0] prod;
    logic signed [ACC_W-1:0]    prod_ext;
    logic signed [ACC_W-1:0]    bias_ext;
    logic signed [ACC_W-1:0]    acc;
    logic signed [ACC_W-1:0]    acc_nx;
    logic signed [ACC_W-1:0]    acc_shr;

    assign x_s      = $signed(x);
    assign w_s      = $signed(w);
    assign b_s      = $signed(bias);
    assign prod     = x_s * w_s;
    assign prod_ext = ACC_W'(prod);
    assign bias_ext = ACC_W'(b_s) <<< FRAC_W;
    assign acc_nx   = load ? (bias_ext + prod_ext) : (acc + prod_ext);

    // Arithmetic shift floors toward -inf; no rounding term is added.
    assign acc_shr  = acc_nx >>> FRAC_W;
    assign res      = DATA_W'(sat_relu(64'(acc_shr), DATA_W, RELU_OUT != 0));

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            acc <= '0;
        else if (en)
            acc <= acc_nx;
    end

endmodule

// File: rtl/neuron_layer_mac.sv
// Fully-connected layer of N_OUT neurons over N_IN inputs, sharing one MAC:
// FSM, loop counters, weight/bias register file and result buffering.
module neuron_layer_mac
    import nn_pkg::*;
#(
    parameter int N_IN     = 3,
    parameter int N_OUT    = 2,
    parameter int DATA_W   = 16,
    parameter int FRAC_W   = 8,
    parameter int ACC_W    = 40,
    parameter int RELU_OUT = 1
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  wen,
    input  logic [clog2(N_OUT*(N_IN+1))-1:0]      waddr,
    input  logic [DATA_W-1:0]                     wdata,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  logic [N_IN*DATA_W-1:0]                in_data,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic [N_OUT*DATA_W-1:0]               out_data,
    output logic                                  busy
);

    localparam int N_W = N_OUT * (N_IN + 1);
    localparam int AW  = clog2(N_W);
    localparam int IW  = clog2(N_IN);
    localparam int JW  = clog2(N_OUT);

    if (ACC_W < min_acc_w(DATA_W, N_IN)) begin : g_acc_w_check
        $error("ACC_W too small for DATA_W and N_IN");
    end

    state_t                   state, state_nx;
    logic [IW-1:0]            cnt_i;
    logic [JW-1:0]            cnt_j;
    logic                     last_i, last_j;
    logic                     accept, mac_en, w_ok;
    logic [AW-1:0]            w_idx, b_idx;
    logic [DATA_W-1:0]        res;
    logic [N_OUT*DATA_W-1:0]  out_q;
    logic signed [DATA_W-1:0] wreg    [N_W];
    logic signed [DATA_W-1:0] in_arr  [N_IN];
    logic signed [DATA_W-1:0] res_buf [N_OUT];

    assign last_i   = (cnt_i == IW'(N_IN - 1));
    assign last_j   = (cnt_j == JW'(N_OUT - 1));
    assign accept   = in_valid & in_ready;
    assign mac_en   = (state == S_MAC);
    assign w_idx    = AW'(int'(cnt_j) * (N_IN + 1) + int'(cnt_i));
    assign b_idx    = AW'(int'(cnt_j) * (N_IN + 1) + N_IN);
    assign out_data = out_q;

    // Writes are frozen during MAC so a running vector never sees mixed weights.
    assign w_ok = wen && (state != S_MAC) && ({1'b0, waddr} < (AW+1)'(N_W));

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= S_IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid)
                    state_nx = S_MAC;
            end
            S_MAC: begin
                busy = 1'b1;
                if (last_i && last_j)
                    state_nx = S_OUT;
            end
            S_OUT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    in_ready = 1'b1;
                    state_nx = in_valid ? S_MAC : S_IDLE;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_i <= '0;
            cnt_j <= '0;
        end else if (mac_en) begin
            if (last_i) begin
                cnt_i <= '0;
                cnt_j <= last_j ? '0 : cnt_j + JW'(1);
            end else begin
                cnt_i <= cnt_i + IW'(1);
            end
        end else begin
            cnt_i <= '0;
            cnt_j <= '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < N_W; k++)
                wreg[k] <= '0;
        end else if (w_ok) begin
            wreg[waddr] <= $signed(wdata);
        end
    end

    always_ff @(posedge clk) begin
        if (accept)
            for (int k = 0; k < N_IN; k++)
                in_arr[k] <= $signed(in_data[k*DATA_W +: DATA_W]);
    end

    nn_mac_unit #(
        .DATA_W   (DATA_W),
        .FRAC_W   (FRAC_W),
        .ACC_W    (ACC_W),
        .RELU_OUT (RELU_OUT)
    ) u_mac (
        .clk  (clk),
        .rst  (rst),
        .en   (mac_en),
        .load (cnt_i == '0),
        .x    (in_arr[cnt_i]),
        .w    (wreg[w_idx]),
        .bias (wreg[b_idx]),
        .res  (res)
    );

    // Results park in res_buf so out_data only changes on entry to OUT.
    always_ff @(posedge clk) begin
        if (mac_en && last_i)
            res_buf[cnt_j] <= $signed(res);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q <= '0;
        end else if (mac_en && last_i && last_j) begin
            for (int k = 0; k < N_OUT; k++)
                out_q[k*DATA_W +: DATA_W] <= (k == N_OUT - 1) ? res : res_buf[k];
        end
    end

endmodule

// File: tb/tb_neuron_layer_mac.sv
// Scoreboard bench: two layer instances (ReLU on / off) share stimulus and are
// checked against a plain-arithmetic dot-product model.
module tb_neuron_layer_mac;

    localparam int NI = 3;
    localparam int NO = 2;
    localparam int DW = 16;
    localparam int FW = 8;
    localparam int AW = 3;
    localparam int NW = NO * (NI + 1);

    logic          clk = 1'b0;
    logic          rst;
    logic          wen;
    logic [AW-1:0] waddr;
    logic [DW-1:0] wdata;
    logic          in_valid;
    logic [NI*DW-1:0] in_data;
    logic          out_ready;
    logic          in_ready_r, out_valid_r, busy_r;
    logic          in_ready_n, out_valid_n, busy_n;
    logic [NO*DW-1:0] out_data_r, out_data_n;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [NO*DW-1:0] exp_r;
        logic [NO*DW-1:0] exp_n;
        int               acc_cyc;
    } txn_t;

    txn_t sb[$];
    int   wm[NW];
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   rand_rdy = 1'b0;

    neuron_layer_mac #(.N_IN(NI), .N_OUT(NO), .DATA_W(DW), .FRAC_W(FW), .ACC_W(40), .RELU_OUT(1)) dut_r (
        .clk(clk), .rst(rst), .wen(wen), .waddr(waddr), .wdata(wdata),
        .in_valid(in_valid), .in_ready(in_ready_r), .in_data(in_data),
        .out_valid(out_valid_r), .out_ready(out_ready), .out_data(out_data_r), .busy(busy_r)
    );

    neuron_layer_mac #(.N_IN(NI), .N_OUT(NO), .DATA_W(DW), .FRAC_W(FW), .ACC_W(40), .RELU_OUT(0)) dut_n (
        .clk(clk), .rst(rst), .wen(wen), .waddr(waddr), .wdata(wdata),
        .in_valid(in_valid), .in_ready(in_ready_n), .in_data(in_data),
        .out_valid(out_valid_n), .out_ready(out_ready), .out_data(out_data_n), .busy(busy_n)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: bias scaled into the product domain, plain dot product,
    // floor division by 2^FW, clamp to the output range, optional ReLU.
    function automatic logic [NO*DW-1:0] model(input logic [NI*DW-1:0] vec, input bit relu);
        logic [NO*DW-1:0] r;
        logic [DW-1:0]    xs;
        longint           acc, v, hi, lo;
        r  = '0;
        hi = (longint'(1) <<< (DW - 1)) - 1;
        lo = -(longint'(1) <<< (DW - 1));
        for (int j = 0; j < NO; j++) begin
            acc = longint'(wm[j*(NI+1) + NI]) * (longint'(1) <<< FW);
            for (int i = 0; i < NI; i++) begin
                xs  = vec[i*DW +: DW];
                acc = acc + longint'($signed(xs)) * longint'(wm[j*(NI+1) + i]);
            end
            v = acc >>> FW;
            if (v > hi) v = hi;
            if (v < lo) v = lo;
            if (relu && v < 0) v = 0;
            r[j*DW +: DW] = v[DW-1:0];
        end
        return r;
    endfunction

    function automatic txn_t make_txn(input logic [NI*DW-1:0] vec);
        txn_t t;
        t.exp_r   = model(vec, 1'b1);
        t.exp_n   = model(vec, 1'b0);
        t.acc_cyc = cyc + 1;
        return t;
    endfunction

    function automatic int to_s16(input int val);
        logic [DW-1:0] v16;
        v16 = val[DW-1:0];
        return int'($signed(v16));
    endfunction

    // Only called while both instances are outside MAC.
    task automatic set_w(input int addr, input int val);
        wen   = 1'b1;
        waddr = AW'(addr);
        wdata = DW'(val);
        @(posedge clk); #1;
        wen = 1'b0;
        wm[addr] = to_s16(val);
    endtask

    task automatic set_neuron(input int j, input int w0, input int w1, input int w2, input int b);
        set_w(j*(NI+1) + 0, w0);
        set_w(j*(NI+1) + 1, w1);
        set_w(j*(NI+1) + 2, w2);
        set_w(j*(NI+1) + 3, b);
    endtask

    task automatic send(input logic [NI*DW-1:0] vec, input bit do_w, input int addr, input int val);
        bit got;
        got = 1'b0;
        in_valid = 1'b1;
        in_data  = vec;
        if (do_w) begin
            wen = 1'b1; waddr = AW'(addr); wdata = DW'(val);
            wm[addr] = to_s16(val);
        end
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (in_ready_r) begin
                got = 1'b1;
                break;
            end
            @(posedge clk); #1;
            if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
        end
        check("accept_seen", got, 1'b1);
        if (got) sb.push_back(make_txn(vec));
        @(posedge clk); #1;
        in_valid = 1'b0;
        wen      = 1'b0;
        if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic wait_idle();
        bit done;
        done = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (sb.size() == 0 && !out_valid_r && !busy_r) begin
                done = 1'b1;
                break;
            end
        end
        check("drain", done, 1'b1);
        @(posedge clk); #1;
    endtask

    function automatic logic [DW-1:0] rv();
        if ($urandom_range(0, 1) == 1)
            return DW'($urandom_range(0, 65535));
        return DW'(int'($urandom_range(0, 2048)) - 1024);
    endfunction

    initial begin : monitor
        bit pv, phs;
        logic [NO*DW-1:0] pdr, pdn;
        txn_t t;
        pv = 1'b0; phs = 1'b0; pdr = '0; pdn = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                pv = 1'b0;
                phs = 1'b0;
            end else begin
                if (out_valid_r) begin
                    if (!pv || phs) begin
                        if (sb.size() == 0) begin
                            n_checks++;
                            n_fail++;
                            $display("FAIL unexpected_out: out_valid with data %0h, expected no pending vector", out_data_r);
                        end else begin
                            check("latency", 64'(cyc - sb[0].acc_cyc), 64'(NI*NO));
                        end
                        check("valid_pair", out_valid_n, 1'b1);
                    end else begin
                        check("hold_relu", out_data_r, pdr);
                        check("hold_lin", out_data_n, pdn);
                    end
                    if (out_ready && sb.size() > 0) begin
                        t = sb.pop_front();
                        check("data_relu", out_data_r, t.exp_r);
                        check("data_lin", out_data_n, t.exp_n);
                    end
                end
                pv  = out_valid_r;
                phs = out_valid_r && out_ready;
                pdr = out_data_r;
                pdn = out_data_n;
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        bit seen;
        logic [NI*DW-1:0] v;
        rst = 1'b0; wen = 1'b0; waddr = '0; wdata = '0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        for (int k = 0; k < NW; k++) wm[k] = 0;
        #2 rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", in_ready_r, 1'b1);
        check("rst_in_ready_n", in_ready_n, 1'b1);
        check("rst_out_valid", out_valid_r, 1'b0);
        check("rst_busy", busy_r, 1'b0);
        check("rst_out_data", out_data_r, '0);
        check("rst_out_data_n", out_data_n, '0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Basic dot products with bias.
        set_neuron(0, 'h0100, 'h0200, 'h0080, 0);
        set_neuron(1, 'h0100, 'h0100, 'h0100, 'h0100);
        send({16'h0200, 16'h0100, 16'h0100}, 1'b0, 0, 0);
        wait_idle();

        // Negative result: clamped by ReLU instance, passed by linear one.
        set_neuron(0, 'hFF00, 0, 0, 0);
        send({16'h0000, 16'h0000, 16'h0300}, 1'b0, 0, 0);
        wait_idle();

        // Saturation at both rails.
        set_neuron(0, 'h7FFF, 'h7FFF, 'h7FFF, 0);
        set_neuron(1, 'h8000, 'h8000, 'h8000, 0);
        send({16'h7FFF, 16'h7FFF, 16'h7FFF}, 1'b0, 0, 0);
        wait_idle();

        // Backpressure, then back-to-back accept as out_ready rises.
        set_neuron(0, 'h0100, 'h0200, 'h0080, 0);
        set_neuron(1, 'h0100, 'h0100, 'h0100, 'h0100);
        out_ready = 1'b0;
        send({16'h0200, 16'h0100, 16'h0100}, 1'b0, 0, 0);
        seen = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (out_valid_r) begin
                seen = 1'b1;
                break;
            end
        end
        check("bp_valid_seen", seen, 1'b1);
        @(posedge clk); #1;
        v = {16'hFF00, 16'h0180, 16'h0040};
        in_valid = 1'b1;
        in_data  = v;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("bp_valid_held", out_valid_r, 1'b1);
            check("bp_in_ready", in_ready_r, 1'b0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_accept", in_ready_r, 1'b1);
        sb.push_back(make_txn(v));
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        check("bp_busy", busy_r, 1'b1);
        wait_idle();

        // Write during MAC is dropped; write coinciding with accept lands first.
        send({16'h0100, 16'h0100, 16'h0200}, 1'b0, 0, 0);
        @(posedge clk); #1;
        wen = 1'b1; waddr = '0; wdata = 16'h7F00;
        @(posedge clk); #1;
        wen = 1'b0;
        send({16'h0080, 16'h0100, 16'h0300}, 1'b0, 0, 0);
        wait_idle();
        send({16'h0100, 16'h0200, 16'h0100}, 1'b1, 1, 'h0300);
        wait_idle();

        // Reset in the middle of MAC discards the vector and clears weights.
        send({16'h0100, 16'h0100, 16'h0100}, 1'b0, 0, 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        sb.delete();
        for (int k = 0; k < NW; k++) wm[k] = 0;
        @(negedge clk);
        check("mid_rst_valid", out_valid_r, 1'b0);
        check("mid_rst_busy", busy_r, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", in_ready_r, 1'b1);
        check("post_rst_valid", out_valid_r, 1'b0);
        @(posedge clk); #1;
        send({16'h0300, 16'h0200, 16'h0100}, 1'b0, 0, 0);
        wait_idle();

        // Randomized vectors, weights and downstream readiness.
        rand_rdy = 1'b1;
        for (int n = 0; n < 30; n++) begin
            if ($urandom_range(0, 2) == 0) begin
                wait_idle();
                for (int k = 0; k < NW; k++)
                    if ($urandom_range(0, 1) == 1) set_w(k, int'(rv()));
            end
            send({rv(), rv(), rv()}, 1'b0, 0, 0);
        end
        rand_rdy = 1'b0;
        wait_idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
